// File: rtl/fpga_bus_master.sv
// fpga_bus_master: byte-wide command master for the FPGA slave bus.
// Generates a continuous bus_clk from clk_in (CLK_DIV cycles low, then
// CLK_DIV high). Each command starts with a one-bus-cycle sync
// (edge 0), followed by per-command write or read bytes.
// Ports:
//   clk_in, rst_n              clock, async active-low reset
//   cmd_valid/cmd_ready        command handshake; cmd_code, wr_data payload
//   rd_data, rd_valid, cmd_err result, one-cycle pulse at completion
//   bus_clk, bus_sync          slave bus clock and DATA_SYNC
//   bus_data_out/_oe/_in       byte bus, external tristate
// Optional feature: define BUS_TEST_CHECK_EN to flag a bus-test echo mismatch.
//
// state | meaning
// IDLE  | ready for a command, bus_clk free-running
// SYNC  | waiting for low-phase boundary, then one sync bus cycle
// XFER  | write/read bytes, one per bus edge
// DONE  | one cycle, rd_valid pulse
module fpga_bus_master #(
  parameter int CLK_DIV = 4
) (
  input  logic        clk_in,
  input  logic        rst_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [2:0]  cmd_code,
  input  logic [63:0] wr_data,
  output logic [63:0] rd_data,
  output logic        rd_valid,
  output logic        cmd_err,
  output logic        bus_clk,
  output logic        bus_sync,
  output logic [7:0]  bus_data_out,
  output logic        bus_data_oe,
  input  logic [7:0]  bus_data_in
);

  localparam logic [7:0] DIV_LOAD = 8'(CLK_DIV - 1);

  typedef enum logic [1:0] {IDLE, SYNC, XFER, DONE} state_t;

  state_t      state, state_nx;
  logic [7:0]  div_cnt;
  logic [2:0]  cmd_lat;
  logic [63:0] wr_sh;
  logic [55:0] rx_sh;
  logic [3:0]  byte_cnt;
  logic        end_high, rise;
  logic [3:0]  n_edges;
  logic        drives_bus, samples_bus, last_edge;
  logic [63:0] rx_next, rd_next;
  logic [6:0]  rd_shift;
  logic        err_next;

  function automatic logic [3:0] edges_of(input logic [2:0] c);
    case (c)
      3'd0:    return 4'd1;
      3'd1:    return 4'd8;
      3'd2:    return 4'd5;
      3'd3:    return 4'd4;
      3'd4:    return 4'd8;
      default: return 4'd0;
    endcase
  endfunction

  // bus_clk divider: down-counter, phase flips at terminal count
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt <= DIV_LOAD;
      bus_clk <= 1'b0;
    end else if (div_cnt == 8'd0) begin
      div_cnt <= DIV_LOAD;
      bus_clk <= ~bus_clk;
    end else begin
      div_cnt <= div_cnt - 8'd1;
    end
  end

  // end_high: last clock of a high phase; registered drive values
  // updated here appear on the first clock of the next low phase.
  assign end_high    = bus_clk && (div_cnt == 8'd0);
  assign rise        = !bus_clk && (div_cnt == 8'd0);
  assign n_edges     = edges_of(cmd_lat);
  assign drives_bus  = (cmd_lat == 3'd0) || (cmd_lat == 3'd1) || (cmd_lat == 3'd3);
  assign samples_bus = (cmd_lat == 3'd0) || (cmd_lat == 3'd2) || (cmd_lat == 3'd4);
  assign last_edge   = (byte_cnt == n_edges);
  assign rx_next     = {rx_sh, bus_data_in};
  // left-justify the received bytes so byte 0 lands in [63:56]
  assign rd_shift    = {4'd8 - n_edges, 3'b000};
  assign rd_next     = samples_bus ? (rx_next << rd_shift) : 64'd0;

`ifdef BUS_TEST_CHECK_EN
  logic [7:0] wr_b0;
  assign err_next = (cmd_lat == 3'd0) && (bus_data_in != wr_b0);
`else
  assign err_next = 1'b0;
`endif

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    cmd_ready = 1'b0;
    rd_valid  = 1'b0;
    case (state)
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) state_nx = (cmd_code == 3'd7) ? DONE : SYNC;
      end
      SYNC: if (end_high && bus_sync) state_nx = (n_edges == 4'd0) ? DONE : XFER;
      XFER: if (end_high && last_edge) state_nx = DONE;
      DONE: begin
        rd_valid = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      cmd_lat      <= 3'd0;
      wr_sh        <= 64'd0;
      rx_sh        <= 56'd0;
      byte_cnt     <= 4'd0;
      bus_sync     <= 1'b0;
      bus_data_out <= 8'd0;
      bus_data_oe  <= 1'b0;
      rd_data      <= 64'd0;
      cmd_err      <= 1'b0;
`ifdef BUS_TEST_CHECK_EN
      wr_b0        <= 8'd0;
`endif
    end else begin
      case (state)
        IDLE: if (cmd_valid) begin
          cmd_lat  <= cmd_code;
          wr_sh    <= wr_data;
          rx_sh    <= 56'd0;
          byte_cnt <= 4'd0;
`ifdef BUS_TEST_CHECK_EN
          wr_b0    <= wr_data[63:56];
`endif
          if (cmd_code == 3'd7) begin
            rd_data <= 64'd0;
            cmd_err <= 1'b1;
          end
        end
        SYNC: if (end_high) begin
          if (!bus_sync) begin
            bus_sync     <= 1'b1;
            bus_data_out <= {5'b0, cmd_lat};
            bus_data_oe  <= 1'b1;
          end else begin
            bus_sync <= 1'b0;
            if (n_edges == 4'd0) begin
              bus_data_out <= 8'd0;
              bus_data_oe  <= 1'b0;
              rd_data      <= 64'd0;
              cmd_err      <= 1'b0;
            end else begin
              bus_data_oe  <= drives_bus;
              bus_data_out <= drives_bus ? wr_sh[63:56] : 8'd0;
              wr_sh        <= {wr_sh[55:0], 8'd0};
            end
          end
        end
        XFER: begin
          if (rise) byte_cnt <= byte_cnt + 4'd1;
          if (end_high) begin
            if (samples_bus) rx_sh <= rx_next[55:0];
            if (last_edge) begin
              bus_data_out <= 8'd0;
              bus_data_oe  <= 1'b0;
              rd_data      <= rd_next;
              cmd_err      <= err_next;
            end else begin
              bus_data_out <= drives_bus ? wr_sh[63:56] : 8'd0;
              wr_sh        <= {wr_sh[55:0], 8'd0};
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fpga_bus_master.sv
// Self-checking bench for fpga_bus_master with a behavioural slave model.
module tb_fpga_bus_master;
  localparam int CD = 2;

  logic        clk_in = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [2:0]  cmd_code = 3'd0;
  logic [63:0] wr_data = 64'd0;
  logic [63:0] rd_data;
  logic        rd_valid, cmd_err, bus_clk, bus_sync, bus_data_oe;
  logic [7:0]  bus_data_out;
  logic [7:0]  bus_data_in;

  int checks = 0;
  int failures = 0;

  // slave model state
  int         s_edges = 0, s_syncs = 0, s_oe_err = 0, s_idx = 0;
  bit         s_active = 1'b0;
  logic [2:0] s_cmd = 3'd0;
  logic [7:0] s_wr[8];
  logic [7:0] s_rd[8];
  logic [7:0] corrupt = 8'd0;

  fpga_bus_master #(.CLK_DIV(CD)) dut (
    .clk_in(clk_in), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_code(cmd_code), .wr_data(wr_data), .rd_data(rd_data), .rd_valid(rd_valid),
    .cmd_err(cmd_err), .bus_clk(bus_clk), .bus_sync(bus_sync),
    .bus_data_out(bus_data_out), .bus_data_oe(bus_data_oe), .bus_data_in(bus_data_in)
  );

  always #5 clk_in = ~clk_in;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Slave: latches command on the sync edge, then one byte per edge.
  initial begin
    bus_data_in = 8'd0;
    forever begin
      @(posedge bus_clk);
      if (bus_sync) begin
        s_active = 1'b1;
        s_cmd    = bus_data_out[2:0];
        s_idx    = 0;
        s_edges++;
        s_syncs++;
        if (!bus_data_oe) s_oe_err++;
      end else if (s_active) begin
        s_idx++;
        s_edges++;
        if (s_cmd inside {3'd0, 3'd1, 3'd3}) begin
          if (!bus_data_oe) s_oe_err++;
          if (s_idx <= 8) s_wr[s_idx-1] = bus_data_out;
        end else if (bus_data_oe) begin
          s_oe_err++;
        end
        if (s_cmd == 3'd0) bus_data_in = bus_data_out ^ corrupt;
        else if (s_cmd inside {3'd2, 3'd4} && s_idx <= 8) bus_data_in = s_rd[s_idx-1];
      end
    end
  end

  function automatic int exp_edges(input logic [2:0] c);
    case (c)
      3'd0: return 2;
      3'd1: return 9;
      3'd2: return 6;
      3'd3: return 5;
      3'd4: return 9;
      3'd5, 3'd6: return 1;
      default: return 0;
    endcase
  endfunction

  function automatic int n_writes(input logic [2:0] c);
    case (c)
      3'd0: return 1;
      3'd1: return 8;
      3'd3: return 4;
      default: return 0;
    endcase
  endfunction

  task automatic set_rd(input logic [63:0] v);
    for (int i = 0; i < 8; i++) s_rd[i] = v[63-8*i -: 8];
  endtask

  task automatic do_cmd(input logic [2:0] code, input logic [63:0] wd);
    int lat, guard, ready_bad, nr, nw;
    bit seen;
    logic [63:0] exp_rd, obs_wr, exp_wr, got_rd;
    logic exp_err, got_err;
    guard = 0;
    @(negedge clk_in);
    while (!cmd_ready && guard < 100) begin @(negedge clk_in); guard++; end
    s_edges = 0; s_syncs = 0; s_oe_err = 0; s_active = 1'b0;
    for (int i = 0; i < 8; i++) s_wr[i] = 8'd0;
    cmd_valid = 1'b1; cmd_code = code; wr_data = wd;
    @(negedge clk_in);
    cmd_valid = 1'b0;
    lat = 1; seen = 1'b0; ready_bad = 0;
    while (lat < 400) begin
      if (rd_valid) begin seen = 1'b1; break; end
      if (cmd_ready) ready_bad++;
      @(negedge clk_in);
      lat++;
    end
    got_rd = rd_data; got_err = cmd_err;
    s_active = 1'b0;
    chk("rd_valid_seen", 64'(seen), 64'd1);
    chk("latency_bound", 64'(lat <= (exp_edges(code) + 2) * 2 * CD + 1), 64'd1);
    if (code == 3'd7) chk("cmd7_latency", 64'(lat <= 3), 64'd1);
    chk("ready_low_busy", 64'(ready_bad), 64'd0);
    chk("edge_count", 64'(s_edges), 64'(exp_edges(code)));
    chk("sync_count", 64'(s_syncs), (code == 3'd7) ? 64'd0 : 64'd1);
    chk("oe_direction", 64'(s_oe_err), 64'd0);
    exp_rd = 64'd0;
    nr = (code == 3'd2) ? 5 : (code == 3'd4) ? 8 : 0;
    for (int i = 0; i < nr; i++) exp_rd[63-8*i -: 8] = s_rd[i];
    if (code == 3'd0) exp_rd = {wd[63:56] ^ corrupt, 56'd0};
    chk("rd_data", got_rd, exp_rd);
    exp_err = (code == 3'd7);
`ifdef BUS_TEST_CHECK_EN
    if (code == 3'd0 && corrupt != 8'd0) exp_err = 1'b1;
`endif
    chk("cmd_err", 64'(got_err), 64'(exp_err));
    nw = n_writes(code);
    obs_wr = 64'd0; exp_wr = 64'd0;
    for (int i = 0; i < nw; i++) begin
      obs_wr[63-8*i -: 8] = s_wr[i];
      exp_wr[63-8*i -: 8] = wd[63-8*i -: 8];
    end
    if (nw > 0) chk("write_bytes", obs_wr, exp_wr);
    @(negedge clk_in);
    chk("rd_valid_pulse", 64'(rd_valid), 64'd0);
  endtask

  initial begin
    int guard, cnt, gap, rdy_bad;
    logic [63:0] wd;
    logic [2:0] code;

    #12;
    chk("rst_bus_clk", 64'(bus_clk), 64'd0);
    chk("rst_outputs", {bus_sync, bus_data_oe, rd_valid, cmd_err, bus_data_out}, 64'd0);
    chk("rst_rd_data", rd_data, 64'd0);
    @(negedge clk_in); rst_n = 1'b1;
    @(negedge clk_in);
    chk("idle_ready", 64'(cmd_ready), 64'd1);

    // bus test, clean echo then corrupted echo
    corrupt = 8'h00;
    do_cmd(3'd0, 64'hA5FF_0000_1111_2222);
    corrupt = 8'hFF;
    do_cmd(3'd0, 64'hA500_0000_0000_0000);
    corrupt = 8'h00;

    // params out: freq and gains as the slave decodes them
    do_cmd(3'd1, 64'h0303_B2AB_2020_2020);
    chk("freq", 64'({s_wr[1], s_wr[2], s_wr[3]} & 24'h3FFFFF), 64'h03B2AB);
    chk("gains", {s_wr[4], s_wr[5], s_wr[6], s_wr[7]}, 64'h2020_2020);

    // RX IQ: spectrum Q,I then voice Q,I
    set_rd({16'h8001, 16'h1234, 16'hFFFE, 16'h0F0F});
    do_cmd(3'd4, 64'd0);
    set_rd({$urandom, $urandom});
    do_cmd(3'd2, 64'd0);
    do_cmd(3'd5, 64'd0);
    do_cmd(3'd6, 64'd0);
    do_cmd(3'd7, 64'd0);

    // reset after edge 2 of a TX IQ command
    @(negedge clk_in);
    cmd_valid = 1'b1; cmd_code = 3'd3; wr_data = {$urandom, $urandom};
    s_active = 1'b0;
    @(negedge clk_in);
    cmd_valid = 1'b0;
    guard = 0;
    while (!(s_active && s_idx >= 2) && guard < 200) begin @(negedge clk_in); guard++; end
    chk("reached_edge2", 64'(s_active && s_idx == 2), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_bus_clk", 64'(bus_clk), 64'd0);
    chk("midrst_outputs", {bus_sync, bus_data_oe, rd_valid, cmd_err, bus_data_out}, 64'd0);
    chk("midrst_rd_data", rd_data, 64'd0);
    s_active = 1'b0;
    @(negedge clk_in); @(negedge clk_in);
    rst_n = 1'b1;
    cnt = 0;
    for (int i = 0; i < 20; i++) begin @(negedge clk_in); if (rd_valid) cnt++; end
    chk("no_rd_valid_after_rst", 64'(cnt), 64'd0);
    wd = {16'hBEEF, 16'h0123, 32'h0};
    do_cmd(3'd3, wd);
    chk("tx_q", {s_wr[0], s_wr[1]}, 64'hBEEF);
    chk("tx_i", {s_wr[2], s_wr[3]}, 64'h0123);

    // randomized commands against the slave model
    for (int t = 0; t < 16; t++) begin
      code = 3'($urandom_range(0, 7));
      wd = {$urandom, $urandom};
      set_rd({$urandom, $urandom});
      corrupt = ($urandom_range(0, 1) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
      repeat ($urandom_range(0, 5)) @(negedge clk_in);
      do_cmd(code, wd);
    end
    corrupt = 8'd0;

    // back-to-back with cmd_valid held high
    @(negedge clk_in);
    cmd_code = 3'd5; cmd_valid = 1'b1;
    rdy_bad = 0;
    for (int k = 0; k < 4; k++) begin
      gap = 0;
      while (!bus_sync && gap < 100) begin @(negedge clk_in); gap++; end
      chk("b2b_sync_seen", 64'(bus_sync), 64'd1);
      if (k > 0) chk("b2b_gap", 64'(gap >= 2 * CD), 64'd1);
      guard = 0;
      while (!rd_valid && guard < 100) begin
        if (cmd_ready) rdy_bad++;
        @(negedge clk_in); guard++;
      end
      chk("b2b_rd_valid", 64'(rd_valid), 64'd1);
    end
    cmd_valid = 1'b0;
    chk("b2b_ready_low", 64'(rdy_bad), 64'd0);
    s_active = 1'b0;
    repeat (10) @(negedge clk_in);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
